// File: rtl/multi_word_cla_pkg.sv
// Shared types and helpers for the multi-word adder built around the 16-bit CLA slice.
package multi_word_cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CHUNK_W   = 16;
  localparam int MAX_WORDS = 8;
  localparam int MAX_W     = CHUNK_W * MAX_WORDS;

  // Narrower operands are zero-extended to MAX_W by the caller.
  function automatic logic [CHUNK_W-1:0] chunk_sel(input logic [MAX_W-1:0] vec,
                                                   input int unsigned idx);
    return vec[idx*CHUNK_W +: CHUNK_W];
  endfunction

endpackage

// File: rtl/multi_word_cla_adder_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit CLA groups joined by a lookahead carry unit.
module CLA_16bit_withLCU (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        c_in,
  output logic [15:0] sum,
  output logic        c_out,
  output logic        p,
  output logic        g
);

  logic [15:0] bp;
  logic [15:0] bg;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;
  logic [15:0] c;

  always_comb begin
    bp = in1 ^ in2;
    bg = in1 & in2;
    gp = '0;
    gg = '0;
    for (int k = 0; k < 4; k++) begin
      gp[k] = &bp[4*k +: 4];
      gg[k] = bg[4*k+3]
            | (bp[4*k+3] & bg[4*k+2])
            | (bp[4*k+3] & bp[4*k+2] & bg[4*k+1])
            | ((&bp[4*k+1 +: 3]) & bg[4*k]);
    end

    // Lookahead carry unit: group carries straight from group P/G and c_in.
    gc[0] = c_in;
    gc[1] = gg[0] | (gp[0] & c_in);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & c_in);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

    c = '0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int i = 1; i < 4; i++) begin
        c[4*k+i] = bg[4*k+i-1] | (bp[4*k+i-1] & c[4*k+i-1]);
      end
    end

    sum   = bp ^ c;
    c_out = gc[4];
    p     = &gp;
    g     = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0]);
  end

endmodule

// File: rtl/multi_word_cla_adder.sv
// Wide adder feeding one 16-bit CLA slice a chunk per cycle, LSB first, carry registered between chunks.
// Optional subtract mode (sub port) is enabled by defining MULTI_WORD_CLA_SUB_EN.
module multi_word_cla_adder
  import multi_word_cla_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int IDX_W = $clog2(WORDS),
  localparam int W     = CHUNK_W * WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic         c_in,
`ifdef MULTI_WORD_CLA_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  state_t             state;
  state_t             state_next;
  logic   [IDX_W-1:0] idx;
  logic               carry;
  logic   [W-1:0]     op_a;
  logic   [W-1:0]     op_b;
  logic               sub_eff;
  logic               accept;
  logic               last;
  logic [CHUNK_W-1:0] slice_a;
  logic [CHUNK_W-1:0] slice_b;
  logic [CHUNK_W-1:0] slice_sum;
  logic               slice_cout;

`ifdef MULTI_WORD_CLA_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign last    = (idx == IDX_W'(WORDS - 1));
  assign slice_a = chunk_sel(MAX_W'(op_a), 32'(idx));
  assign slice_b = chunk_sel(MAX_W'(op_b), 32'(idx));

  CLA_16bit_withLCU cla16_slice (
    .in1   (slice_a),
    .in2   (slice_b),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_cout),
    .p     (),
    .g     ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Subtraction is in1 + ~in2 + 1, so B is inverted at capture and overflow sees the inverted MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_a  <= in1;
      op_b  <= sub_eff ? ~in2 : in2;
      carry <= sub_eff ? 1'b1 : c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      sum[idx*CHUNK_W +: CHUNK_W] <= slice_sum;
      carry                       <= slice_cout;
      if (last) begin
        c_out    <= slice_cout;
        overflow <= (op_a[W-1] == op_b[W-1]) && (slice_sum[CHUNK_W-1] != op_a[W-1]);
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_word_cla_adder.sv
// Scoreboard bench for multi_word_cla_adder (WORDS=4); covers subtract mode when MULTI_WORD_CLA_SUB_EN is defined.
module tb_multi_word_cla_adder;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         c_in = 1'b0;
`ifdef MULTI_WORD_CLA_SUB_EN
  logic         sub = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  multi_word_cla_adder #(.WORDS(WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in1      (in1),
    .in2      (in2),
    .c_in     (c_in),
`ifdef MULTI_WORD_CLA_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb);
    logic [W-1:0] be;
    logic [W:0]   t;
    exp_t         e;
    be   = sb ? ~b : b;
    t    = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    e.s  = t[W-1:0];
    e.co = t[W];
    e.ov = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic ci, input logic sb);
    in1   = a;
    in2   = b;
    c_in  = ci;
`ifdef MULTI_WORD_CLA_SUB_EN
    sub   = sb;
`endif
    start = 1'b1;
    q.push_back(model(a, b, ci, sb));
    @(negedge clk);
    start = 1'b0;
    in1   = ~a;
    in2   = {b[W/2-1:0], b[W-1:W/2]};
    c_in  = ~ci;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({busy, done, sum, c_out, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h c_out=%b ov=%b expected all zero",
               busy, done, sum, c_out, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [W-1:0] ta [8];
    logic [W-1:0] tb_ [8];
    logic         tc [8];
    exp_t e;
    int   cyc;
    bit   ok;
    ta[0] = 64'd3745;                tb_[0] = 64'd16285; tc[0] = 1'b0;
    ta[1] = 64'h0000_0000_0000_FFFF; tb_[1] = 64'd1;     tc[1] = 1'b0;
    ta[2] = 64'hFFFF_FFFF_FFFF_FFFF; tb_[2] = 64'd0;     tc[2] = 1'b1;
    ta[3] = 64'h7FFF_FFFF_FFFF_FFFF; tb_[3] = 64'd1;     tc[3] = 1'b0;
    for (int i = 4; i < 8; i++) begin
      ta[i]  = {$urandom, $urandom};
      tb_[i] = {$urandom, $urandom};
      tc[i]  = 1'($urandom_range(0, 1));
    end
    ta[7][W-1] = 1'b1; tb_[7][W-1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_start(ta[i], tb_[i], tc[i], 1'b0);
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL busy_in_run[%0d]: busy=%b expected 1", i, busy);
      end
      wait_done(cyc, ok);
      tests++;
      if (!ok || cyc != WORDS) begin
        fails++;
        $display("FAIL latency[%0d]: done_seen=%0d cycles=%0d expected %0d", i, ok, cyc, WORDS);
      end
      e = q.pop_front();
      tests++;
      if (sum !== e.s || c_out !== e.co || overflow !== e.ov) begin
        fails++;
        $display("FAIL add[%0d]: sum=%h c_out=%b ov=%b expected sum=%h c_out=%b ov=%b",
                 i, sum, c_out, overflow, e.s, e.co, e.ov);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== e.s) begin
        fails++;
        $display("FAIL idle_hold[%0d]: done=%b busy=%b sum=%h expected 0 0 %h",
                 i, done, busy, sum, e.s);
      end
    end
  endtask

  task automatic test_start_during_run();
    exp_t e;
    int   cyc;
    bit   ok;
    bit   extra;
    drive_start(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    in1   = 64'hAAAA_AAAA_AAAA_AAAA;
    in2   = 64'h5555_5555_5555_5555;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(cyc, ok);
    tests++;
    if (!ok || cyc != WORDS - 2) begin
      fails++;
      $display("FAIL run_start_latency: done_seen=%0d cycles=%0d expected %0d", ok, cyc, WORDS - 2);
    end
    e = q.pop_front();
    tests++;
    if (sum !== e.s || c_out !== e.co || overflow !== e.ov) begin
      fails++;
      $display("FAIL run_start_ignored: sum=%h c_out=%b ov=%b expected sum=%h c_out=%b ov=%b",
               sum, c_out, overflow, e.s, e.co, e.ov);
    end
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      extra |= done | busy;
    end
    tests++;
    if (extra !== 1'b0) begin
      fails++;
      $display("FAIL run_start_no_second_op: activity=%b expected 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw;
    drive_start(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(q.pop_back());
    tests++;
    if ({busy, done, sum, c_out, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h c_out=%b ov=%b expected all zero",
               busy, done, sum, c_out, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw |= done | busy;
    end
    tests++;
    if (saw !== 1'b0 || sum !== '0) begin
      fails++;
      $display("FAIL reset_no_done: activity=%b sum=%h expected 0 and 0", saw, sum);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc;
    bit   ok;
    drive_start(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0);
    wait_done(cyc, ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum !== e.s || c_out !== e.co || overflow !== e.ov) begin
      fails++;
      $display("FAIL b2b_first: done_seen=%0d sum=%h c_out=%b ov=%b expected sum=%h c_out=%b ov=%b",
               ok, sum, c_out, overflow, e.s, e.co, e.ov);
    end
    drive_start(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_no_bubble: busy=%b expected 1", busy);
    end
    wait_done(cyc, ok);
    tests++;
    if (!ok || cyc != WORDS) begin
      fails++;
      $display("FAIL b2b_latency: done_seen=%0d cycles=%0d expected %0d", ok, cyc, WORDS);
    end
    e = q.pop_front();
    tests++;
    if (sum !== e.s || c_out !== e.co || overflow !== e.ov) begin
      fails++;
      $display("FAIL b2b_second: sum=%h c_out=%b ov=%b expected sum=%h c_out=%b ov=%b",
               sum, c_out, overflow, e.s, e.co, e.ov);
    end
    @(negedge clk);
  endtask

`ifdef MULTI_WORD_CLA_SUB_EN
  task automatic test_sub();
    logic [W-1:0] sa [3];
    logic [W-1:0] sb_ [3];
    logic [W-1:0] rs [3];
    logic         rc [3];
    int   cyc;
    bit   ok;
    sa[0] = 64'd5; sb_[0] = 64'd7; rs[0] = 64'hFFFF_FFFF_FFFF_FFFE; rc[0] = 1'b0;
    sa[1] = 64'd7; sb_[1] = 64'd5; rs[1] = 64'd2;                   rc[1] = 1'b1;
    sa[2] = 64'h0001_0000_0000_0000; sb_[2] = 64'd1;
    rs[2] = 64'h0000_FFFF_FFFF_FFFF; rc[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_start(sa[i], sb_[i], 1'(i), 1'b1);
      wait_done(cyc, ok);
      void'(q.pop_front());
      tests++;
      if (!ok || sum !== rs[i] || c_out !== rc[i]) begin
        fails++;
        $display("FAIL sub[%0d]: done_seen=%0d sum=%h c_out=%b expected sum=%h c_out=%b",
                 i, ok, sum, c_out, rs[i], rc[i]);
      end
      @(negedge clk);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_vectors();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
`ifdef MULTI_WORD_CLA_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
